// File: rtl/seq_detect_param_if.sv
// Control and data bundle for seq_detect_param: configuration load, serial
// input, clear, and the match/count results. The master drives the inputs;
// the detector is the slave.
interface seq_detect_param_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned LW    = $clog2(W + 1),
  parameter int unsigned CNT_W = 8
);
  logic             load;
  logic [W-1:0]     pat_in;
  logic [LW-1:0]    len_in;
  logic             ovl_in;
  logic             clr;
  logic             en;
  logic             i;
  logic             o;
  logic [CNT_W-1:0] count;
  logic             sat;

  modport master (
    output load, pat_in, len_in, ovl_in, clr, en, i,
    input  o, count, sat
  );

  modport slave (
    input  load, pat_in, len_in, ovl_in, clr, en, i,
    output o, count, sat
  );
endinterface

// File: rtl/seq_detect_param.sv
// Run-time-configurable serial pattern detector. Shifts in one bit per
// enabled clock, compares the newest len bits against pat, and emits a
// registered one-cycle match pulse plus a saturating match counter.
module seq_detect_param #(
  parameter int unsigned W       = 8,
  parameter int unsigned LW      = $clog2(W + 1),
  parameter int unsigned CNT_W   = 8,
  parameter logic [W-1:0] DEF_PAT = W'('b1101),
  parameter int unsigned DEF_LEN = 4
) (
  input logic               clk,
  input logic               n_rst,
  seq_detect_param_if.slave bus
);

  // Internal length/fill width only needs to hold 0..W.
  localparam int unsigned FW = $clog2(W + 1);

  logic [W-1:0]     pat, pat_nx;
  logic [FW-1:0]    len, len_nx;
  logic             ovl, ovl_nx;
  logic [W-1:0]     hist, hist_nx;
  logic [FW-1:0]    fill, fill_nx;
  logic             o, o_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             sat, sat_nx;

  logic [LW-1:0]    len_in_w;
  logic [W-1:0]     shifted;
  logic [FW-1:0]    fill_inc;
  logic [W-1:0]     mask;
  logic             hit;

  assign len_in_w = bus.len_in;

  // Next-state: load has priority over a bit offered on the same edge;
  // clr overrides the counter update but not the match pulse.
  always_comb begin
    pat_nx   = pat;
    len_nx   = len;
    ovl_nx   = ovl;
    hist_nx  = hist;
    fill_nx  = fill;
    o_nx     = 1'b0;
    count_nx = count;
    sat_nx   = sat;
    hit      = 1'b0;

    shifted  = {hist[W-2:0], bus.i};
    fill_inc = (fill == FW'(W)) ? fill : fill + FW'(1);
    mask     = ~({W{1'b1}} << len);

    if (bus.load) begin
      pat_nx  = bus.pat_in;
      ovl_nx  = bus.ovl_in;
      len_nx  = (32'(len_in_w) > W) ? FW'(W) : FW'(len_in_w);
      fill_nx = '0;
    end else if (bus.en) begin
      hist_nx = shifted;
      fill_nx = fill_inc;
      hit = (len != '0) && (fill_inc >= len) && (((shifted ^ pat) & mask) == '0);
      if (hit) begin
        o_nx = 1'b1;
        if (!ovl) fill_nx = '0;
        if (count != '1) count_nx = count + CNT_W'(1);
        if (count_nx == '1) sat_nx = 1'b1;
      end
    end

    if (bus.clr) begin
      count_nx = '0;
      sat_nx   = 1'b0;
    end
  end

  // State register with asynchronous active-low reset to the default config.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pat   <= DEF_PAT;
      len   <= FW'(DEF_LEN);
      ovl   <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      o     <= 1'b0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      pat   <= pat_nx;
      len   <= len_nx;
      ovl   <= ovl_nx;
      hist  <= hist_nx;
      fill  <= fill_nx;
      o     <= o_nx;
      count <= count_nx;
      sat   <= sat_nx;
    end
  end

  assign bus.o     = o;
  assign bus.count = count;
  assign bus.sat   = sat;

endmodule
